// File: rtl/gelu_batch_scheduler_if.sv
// Handshake and buffer bus between the layer controller, the buffers,
// the GELU activation unit and gelu_batch_scheduler.
//
// Signals:
//   start/base_src/base_dst/length  batch launch and configuration
//   hold                            stalls issue of new source reads
//   src_rd_en/src_addr/src_rd_data  source buffer read port
//   act_in/act_valid/act_out        activation unit operand/result
//   dst_wr_en/dst_addr/dst_wr_data  destination buffer write port
//   busy/done/elem_count            batch status
//
// master: the scheduler side. slave: controller, buffers and datapath.
interface gelu_batch_scheduler_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_src;
    logic [ADDR_W-1:0] base_dst;
    logic [ADDR_W-1:0] length;
    logic              hold;

    logic              src_rd_en;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_rd_data;

    logic [DATA_W-1:0] act_in;
    logic              act_valid;
    logic [DATA_W-1:0] act_out;

    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst_wr_data;

    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] elem_count;

    modport master (
        input  start,
        input  base_src,
        input  base_dst,
        input  length,
        input  hold,
        output src_rd_en,
        output src_addr,
        input  src_rd_data,
        output act_in,
        output act_valid,
        input  act_out,
        output dst_wr_en,
        output dst_addr,
        output dst_wr_data,
        output busy,
        output done,
        output elem_count
    );

    modport slave (
        output start,
        output base_src,
        output base_dst,
        output length,
        output hold,
        input  src_rd_en,
        input  src_addr,
        output src_rd_data,
        input  act_in,
        input  act_valid,
        output act_out,
        input  dst_wr_en,
        input  dst_addr,
        input  dst_wr_data,
        input  busy,
        input  done,
        input  elem_count
    );
endinterface

// File: rtl/gelu_batch_scheduler.sv
// Streams a batch of Q3.5 activations through one shared fixed-latency
// GELU unit: reads source buffer, tags in-flight elements, writes results.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    gelu_batch_scheduler_if.master (config, buffers, act unit, status)
module gelu_batch_scheduler #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int ACT_LAT = 2
) (
    input logic                  clk,
    input logic                  reset,
    gelu_batch_scheduler_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] src_base_q;
    logic [ADDR_W-1:0] dst_base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issued_q;
    logic [ADDR_W-1:0] issued_nx;
    logic [ADDR_W-1:0] elem_q;

    // Tag pipe: stage 0 lines up with act_valid, stage ACT_LAT with act_out.
    logic [ACT_LAT:0]  tag_v_q;
    logic [ADDR_W-1:0] tag_a_q [ACT_LAT+1];

    logic              load;
    logic              issue;
    logic              busy_c;
    logic              done_c;
    logic              wr_c;
    logic [DATA_W-1:0] result;

    assign issued_nx = issued_q + ADDR_W'(1);
    assign wr_c      = tag_v_q[ACT_LAT];
    assign result    = bus.act_out;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        issue   = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = (bus.length != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (!bus.hold) begin
                    issue = 1'b1;
                    if (issued_nx == len_q)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
                // Only the stage being written this cycle may still be live.
                if (tag_v_q[ACT_LAT-1:0] == '0)
                    state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
            issued_q   <= '0;
        end else if (load) begin
            src_base_q <= bus.base_src;
            dst_base_q <= bus.base_dst;
            len_q      <= bus.length;
            issued_q   <= '0;
        end else if (issue) begin
            issued_q   <= issued_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            elem_q <= '0;
        else if (load)
            elem_q <= '0;
        else if (wr_c)
            elem_q <= elem_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v_q <= '0;
            for (int i = 0; i <= ACT_LAT; i++)
                tag_a_q[i] <= '0;
        end else begin
            tag_v_q    <= {tag_v_q[ACT_LAT-1:0], issue};
            tag_a_q[0] <= dst_base_q + issued_q;
            for (int i = 1; i <= ACT_LAT; i++)
                tag_a_q[i] <= tag_a_q[i-1];
        end
    end

    assign bus.src_rd_en   = issue;
    assign bus.src_addr    = issue ? (src_base_q + issued_q) : '0;
    assign bus.act_valid   = tag_v_q[0];
    assign bus.act_in      = bus.src_rd_data;
    assign bus.dst_wr_en   = wr_c;
    assign bus.dst_addr    = wr_c ? tag_a_q[ACT_LAT] : '0;
    assign bus.dst_wr_data = result;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.elem_count  = elem_q;

endmodule
